// File: rtl/spi_cfg_sequencer_if.sv
// spi_cfg_sequencer_if: SPI pins, generation lock and configuration outputs of spi_cfg_sequencer
interface spi_cfg_sequencer_if #(parameter int NREGS = 8);
  logic i_SPI_CS;
  logic i_SPI_MOSI;
  logic i_lock;
  logic o_SPI_MISO;
  logic [NREGS*16-1:0] o_cfg_active;
  logic o_commit;
  logic [7:0] o_status;
  modport master(output i_SPI_CS, i_SPI_MOSI, i_lock, input o_SPI_MISO, o_cfg_active, o_commit, o_status);
  modport slave(input i_SPI_CS, i_SPI_MOSI, i_lock, output o_SPI_MISO, o_cfg_active, o_commit, o_status);
endinterface

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: 24-bit framed SPI config with shadow/active banks and atomic commit.
// Define SPI_CFG_PARITY_EN to drop frames without odd overall parity and count them.
module spi_cfg_sequencer #(
  parameter int NREGS = 8,
  parameter logic [7:0] DEV_ID = 8'hB0
) (
  input logic i_SPI_CLK,
  input logic w_main_reset,
  spi_cfg_sequencer_if.slave bus
);
  localparam logic [5:0] NR = 6'(NREGS);
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_CM = 2'b11;
  logic [4:0] cnt;
  logic [22:0] rx;
  logic [23:0] tx;
  logic [15:0] shadow [NREGS];
  logic [NREGS*16-1:0] active;
  logic commit_q;
  logic [3:0] rej, perr;
  logic dec, ok, in_rng, wr, rd, cm, cm_ok;
  logic [1:0] op;
  logic [4:0] addr;
  logic [15:0] data, rsh, rdata;
  logic [NREGS-1:0] dm, msk;
  always_comb begin
    op = rx[22:21];
    addr = rx[19:15];
    data = {rx[14:0], bus.i_SPI_MOSI};
    dec = !bus.i_SPI_CS && cnt == 5'd23;
`ifdef SPI_CFG_PARITY_EN
    ok = ^{rx, bus.i_SPI_MOSI};
`else
    ok = 1'b1;
`endif
    in_rng = {1'b0, addr} < NR;
    wr = dec && ok && op == OP_WR && in_rng;
    rd = dec && ok && op == OP_RD;
    cm = dec && ok && op == OP_CM;
    cm_ok = cm && !bus.i_lock;
    dm = (NREGS)'(data);
    msk = dm == '0 ? '1 : dm;
    rsh = '0;
    for (int k = 0; k < NREGS; k++) if (addr == 5'(k)) rsh = shadow[k];
    rdata = in_rng ? rsh : addr == 5'd31 ? {DEV_ID, rej, perr} : 16'h0;
  end
  // Chip select high clears only the frame assembly, never tx or status.
  always_ff @(posedge i_SPI_CLK or posedge w_main_reset or posedge bus.i_SPI_CS)
    if (w_main_reset || bus.i_SPI_CS) begin
      cnt <= '0;
      rx <= '0;
    end else begin
      cnt <= dec ? 5'd0 : cnt + 5'd1;
      rx <= {rx[21:0], bus.i_SPI_MOSI};
    end
  always_ff @(posedge i_SPI_CLK or posedge w_main_reset)
    if (w_main_reset) begin
      tx <= '0;
      commit_q <= 1'b0;
      rej <= '0;
      perr <= '0;
    end else begin
      tx <= rd ? {2'b10, 1'b0, addr, rdata} : dec ? 24'h0 : {tx[22:0], 1'b0};
      commit_q <= cm_ok;
      if (cm && bus.i_lock && rej != 4'hF) rej <= rej + 4'd1;
`ifdef SPI_CFG_PARITY_EN
      if (dec && !ok && perr != 4'hF) perr <= perr + 4'd1;
`endif
    end
  // Banks deliberately skip reset so configuration outlives each generation-end reset.
  always_ff @(posedge i_SPI_CLK)
    for (int k = 0; k < NREGS; k++) begin
      if (wr && addr == 5'(k)) shadow[k] <= data;
      if (cm_ok && msk[k]) active[16*k +: 16] <= shadow[k];
    end
  assign bus.o_SPI_MISO = !bus.i_SPI_CS && tx[23];
  assign bus.o_cfg_active = active;
  assign bus.o_commit = commit_q;
  assign bus.o_status = {rej, perr};
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: scoreboard bench; each frame's expected MISO stream is queued when the prior frame is sent.
module tb_spi_cfg_sequencer;
  localparam int NREGS = 8;
`ifdef SPI_CFG_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_bank = 1'b0;
  logic [15:0] sh_m [NREGS];
  logic [15:0] ac_m [NREGS];
  logic [3:0] rej_m = '0;
  logic [3:0] perr_m = '0;
  logic [23:0] exp_q [$];
  spi_cfg_sequencer_if #(.NREGS(NREGS)) bus();
  spi_cfg_sequencer #(.NREGS(NREGS), .DEV_ID(8'hB0)) dut(.i_SPI_CLK(clk), .w_main_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] rd_m(input logic [4:0] a);
    if (int'(a) < NREGS) return sh_m[a];
    if (a == 5'd31) return {8'hB0, rej_m, perr_m};
    return 16'h0;
  endfunction
  function automatic logic [NREGS*16-1:0] ac_pack();
    logic [NREGS*16-1:0] v;
    for (int k = 0; k < NREGS; k++) v[16*k +: 16] = ac_m[k];
    return v;
  endfunction
  task automatic send_frame(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] data,
                            input bit keep = 1'b0, input bit bad = 1'b0);
    logic [23:0] w, got, exp, ld;
    logic [NREGS-1:0] m;
    logic cexp;
    w = {op, 1'b0, addr, data};
    w[21] = ~^w ^ bad;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.i_SPI_CS = 1'b0;
      bus.i_SPI_MOSI = w[23-i];
      #1 got[23-i] = bus.o_SPI_MISO;
    end
    exp = exp_q.size() != 0 ? exp_q.pop_front() : 24'h0;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL miso_stream op=%b addr=%0d: got %h expected %h", op, addr, got, exp);
    end
    ld = 24'h0;
    cexp = 1'b0;
    if (PEN && bad) begin
      if (perr_m != 4'hF) perr_m++;
    end else if (op == 2'b01) begin
      if (int'(addr) < NREGS) sh_m[addr] = data;
    end else if (op == 2'b10) begin
      ld = {2'b10, 1'b0, addr, rd_m(addr)};
    end else if (op == 2'b11) begin
      if (bus.i_lock) begin
        if (rej_m != 4'hF) rej_m++;
      end else begin
        cexp = 1'b1;
        m = data[NREGS-1:0] == '0 ? '1 : data[NREGS-1:0];
        for (int k = 0; k < NREGS; k++) if (m[k]) ac_m[k] = sh_m[k];
      end
    end
    exp_q.push_back(ld);
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.o_commit !== cexp) begin
      n_fail++;
      $display("FAIL commit_pulse op=%b: got %b expected %b", op, bus.o_commit, cexp);
    end
    n_tests++;
    if (bus.o_status !== {rej_m, perr_m}) begin
      n_fail++;
      $display("FAIL status op=%b: got %h expected %h", op, bus.o_status, {rej_m, perr_m});
    end
    if (chk_bank) begin
      n_tests++;
      if (bus.o_cfg_active !== ac_pack()) begin
        n_fail++;
        $display("FAIL active_bank op=%b: got %h expected %h", op, bus.o_cfg_active, ac_pack());
      end
    end
    if (!keep) bus.i_SPI_CS = 1'b1;
  endtask
  task automatic partial(input int n, input logic [23:0] w);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_SPI_CS = 1'b0;
      bus.i_SPI_MOSI = w[23-i];
    end
  endtask
  task automatic test_reset();
    bus.i_SPI_CS = 1'b1;
    bus.i_SPI_MOSI = 1'b0;
    bus.i_lock = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.i_SPI_CS = 1'b0;
    #1;
    n_tests++;
    if (bus.o_SPI_MISO !== 1'b0 || bus.o_commit !== 1'b0 || bus.o_status !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got miso=%b commit=%b status=%h expected 0 0 00",
               bus.o_SPI_MISO, bus.o_commit, bus.o_status);
    end
    @(negedge clk);
    bus.i_SPI_CS = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    for (int k = 0; k < NREGS; k++) begin
      sh_m[k] = 16'h0;
      ac_m[k] = 16'h0;
      send_frame(2'b01, 5'(k), 16'h0);
    end
    send_frame(2'b11, 5'd0, 16'h0);
    chk_bank = 1'b1;
    n_tests++;
    if (bus.o_cfg_active !== '0) begin
      n_fail++;
      $display("FAIL init_bank: got %h expected 0", bus.o_cfg_active);
    end
  endtask
  task automatic test_write_read();
    send_frame(2'b01, 5'd2, 16'h1234);
    send_frame(2'b10, 5'd2, 16'h0);
    send_frame(2'b00, 5'd0, 16'h0);
    n_tests++;
    if (bus.o_cfg_active[47:32] !== 16'h0) begin
      n_fail++;
      $display("FAIL active_before_commit: got %h expected 0000", bus.o_cfg_active[47:32]);
    end
    send_frame(2'b01, 5'd9, 16'hDEAD);
    send_frame(2'b10, 5'd9, 16'h0);
    send_frame(2'b00, 5'd0, 16'h0);
  endtask
  task automatic test_commit();
    send_frame(2'b11, 5'd0, 16'h0);
    n_tests++;
    if (bus.o_cfg_active[47:32] !== 16'h1234) begin
      n_fail++;
      $display("FAIL commit_reg2: got %h expected 1234", bus.o_cfg_active[47:32]);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.o_commit !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_clear: got %b expected 0", bus.o_commit);
    end
  endtask
  task automatic test_lock();
    send_frame(2'b01, 5'd3, 16'h0F0F);
    bus.i_lock = 1'b1;
    send_frame(2'b11, 5'd0, 16'h0);
    n_tests++;
    if (bus.o_status !== 8'h10) begin
      n_fail++;
      $display("FAIL lock_reject_first: got %h expected 10", bus.o_status);
    end
    for (int i = 0; i < 16; i++) send_frame(2'b11, 5'd0, 16'h0, 1'b1);
    n_tests++;
    if (bus.o_status !== 8'hF0) begin
      n_fail++;
      $display("FAIL lock_reject_saturate: got %h expected F0", bus.o_status);
    end
    bus.i_lock = 1'b0;
    send_frame(2'b10, 5'd31, 16'h0);
    send_frame(2'b00, 5'd0, 16'h0);
  endtask
  task automatic test_mask();
    send_frame(2'b01, 5'd0, 16'hAAAA);
    send_frame(2'b01, 5'd1, 16'h5555);
    send_frame(2'b11, 5'd0, 16'h0001);
    n_tests++;
    if (bus.o_cfg_active[31:0] !== 32'h0000_AAAA) begin
      n_fail++;
      $display("FAIL masked_commit: got %h expected 0000aaaa", bus.o_cfg_active[31:0]);
    end
  endtask
  task automatic test_abort();
    partial(10, {2'b01, 1'b0, 5'd4, 16'hFFFF});
    @(negedge clk);
    bus.i_SPI_CS = 1'b1;
    send_frame(2'b01, 5'd5, 16'hBEEF);
    send_frame(2'b10, 5'd4, 16'h0);
    send_frame(2'b10, 5'd5, 16'h0);
    send_frame(2'b00, 5'd0, 16'h0);
  endtask
  task automatic test_back_to_back();
    send_frame(2'b01, 5'd6, 16'hC001, 1'b1);
    send_frame(2'b10, 5'd6, 16'h0, 1'b1);
    send_frame(2'b11, 5'd0, 16'h0040, 1'b1);
    send_frame(2'b00, 5'd0, 16'h0);
  endtask
  task automatic test_reset_mid();
    partial(10, {2'b01, 1'b0, 5'd6, 16'h0000});
    rst = 1'b1;
    @(negedge clk);
    bus.i_SPI_CS = 1'b1;
    rst = 1'b0;
    rej_m = '0;
    perr_m = '0;
    exp_q.delete();
    n_tests++;
    if (bus.o_status !== 8'h00 || bus.o_cfg_active !== ac_pack()) begin
      n_fail++;
      $display("FAIL reset_retains_bank: got status=%h bank=%h expected 00 %h",
               bus.o_status, bus.o_cfg_active, ac_pack());
    end
    send_frame(2'b10, 5'd6, 16'h0);
    send_frame(2'b10, 5'd31, 16'h0);
    send_frame(2'b00, 5'd0, 16'h0);
  endtask
  task automatic test_parity();
    if (PEN) begin
      send_frame(2'b01, 5'd2, 16'h7777, 1'b0, 1'b1);
      n_tests++;
      if (bus.o_status[3:0] !== 4'd1) begin
        n_fail++;
        $display("FAIL parity_count: got %h expected 1", bus.o_status[3:0]);
      end
      send_frame(2'b10, 5'd2, 16'h0);
      send_frame(2'b10, 5'd31, 16'h0);
      send_frame(2'b00, 5'd0, 16'h0);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_write_read();
    test_commit();
    test_lock();
    test_mask();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
